// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type, default frame timing and small sizing helpers for uart_tx_arb.
// Optional feature macro used by the arbiter: UART_TX_ARB_FIXED_PRIO_EN.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_FRAME = 2'd2,
    ST_GAP   = 2'd3
  } uart_state_e;

  localparam int UART_FRAME_TICKS = 10;
  localparam int UART_GAP_TICKS   = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: picks one requester; round-robin after i_last by default,
// fixed lowest-index priority when UART_TX_ARB_FIXED_PRIO_EN is defined.
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);

  logic [IW-1:0] w_last_eff;
  logic [IW-1:0] w_cand;
  logic          w_found;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  // Pretending the last grant was NREQ-1 makes the search start at index 0.
  logic w_unused_last;
  assign w_unused_last = ^i_last;
  assign w_last_eff    = IW'(NREQ - 1);
`else
  assign w_last_eff = i_last;
`endif

  // Scan from the slot after the effective last grant, wrapping once.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(w_last_eff) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx among NREQ byte requesters, one frame plus gap per grant.
// Arbitration variant selected by UART_TX_ARB_FIXED_PRIO_EN (see uart_rr_arb).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int FRAME_TICKS = UART_FRAME_TICKS,
  parameter int GAP_TICKS   = UART_GAP_TICKS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_uart,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*8-1:0]         req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  output logic                      busy,
  output logic [idx_width(NREQ)-1:0] grant_id
);

  localparam int IW = idx_width(NREQ);
  localparam int CW = $clog2(max_int(FRAME_TICKS, GAP_TICKS) + 1);

  uart_state_e   r_state;
  uart_state_e   w_next;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tx_data;
  logic [IW-1:0] r_grant_id;
  logic          r_tx_start;
  logic          r_busy;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic [7:0]      w_byte;
  logic            w_accept;
  logic            w_frame_done;
  logic            w_gap_done;

  uart_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req   (req_valid),
    .i_last  (r_grant_id),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // One-hot grant steers the winner's byte.
  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      w_byte = w_byte | ({8{w_grant[i]}} & req_data[8*i +: 8]);
    end
  end

  assign w_frame_done = clk_uart && (r_cnt == CW'(FRAME_TICKS - 1));
  assign w_gap_done   = clk_uart && (r_cnt == CW'(GAP_TICKS - 1));

  // Next-state logic; a grant is only taken in IDLE.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_next   = ST_START;
          w_accept = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START: w_next = ST_FRAME;
      ST_FRAME: begin
        if (w_frame_done) begin
          w_next = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;
        end else begin
          w_next = ST_FRAME;
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_GAP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, tick counter and registered outputs; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_grant_id <= IW'(NREQ - 1);
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (clk_uart && ((r_state == ST_FRAME) || (r_state == ST_GAP))) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_accept) begin
        r_tx_data  <= w_byte;
        r_grant_id <= w_idx;
      end else begin
        r_tx_data  <= r_tx_data;
        r_grant_id <= r_grant_id;
      end
      r_tx_start <= (w_next == ST_START);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

  assign req_ready = (w_accept && rst_n) ? w_grant : '0;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed checks of uart_tx_arb (default timing) plus a GAP_TICKS=0 instance.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_uart;
  logic [3:0]  req_valid;
  logic [31:0] req_data;

  logic [3:0]  req_ready,  req_ready0;
  logic        tx_start,   tx_start0;
  logic [7:0]  tx_data,    tx_data0;
  logic        busy,       busy0;
  logic [1:0]  grant_id,   grant_id0;

  int vec     = 0;
  int errs    = 0;
  int n_start = 0;

  logic [7:0] exp_byte [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
`ifdef UART_TX_ARB_FIXED_PRIO_EN
  int exp_all [5] = '{0, 0, 0, 0, 0};
  int exp_odd [3] = '{1, 1, 1};
`else
  int exp_all [5] = '{0, 1, 2, 3, 0};
  int exp_odd [3] = '{1, 3, 1};
`endif

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(4), .FRAME_TICKS(10), .GAP_TICKS(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_uart  (clk_uart),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  uart_tx_arb #(.NREQ(4), .FRAME_TICKS(10), .GAP_TICKS(0)) u_dut_g0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_uart  (clk_uart),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready0),
    .tx_start  (tx_start0),
    .tx_data   (tx_data0),
    .busy      (busy0),
    .grant_id  (grant_id0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n baud ticks, each one cycle high then one cycle low; counts tx_start pulses seen.
  task automatic frame_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); clk_uart = 1'b1; #1;
      if (tx_start) n_start++;
      @(negedge clk); clk_uart = 1'b0; #1;
      if (tx_start) n_start++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; req_valid = 4'b0000; clk_uart = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Called in IDLE with requests pending; expects requester e to win one full frame+gap.
  task automatic grant_round(input int e);
    chk("rr_ready", 32'(req_ready), 32'(1 << e));
    @(negedge clk); #1;
    chk("rr_tx_start", 32'(tx_start), 32'd1);
    chk("rr_grant_id", 32'(grant_id), 32'(e));
    chk("rr_tx_data", 32'(tx_data), 32'(exp_byte[e]));
    n_start = 0;
    frame_ticks(11);
    chk("rr_one_start", 32'(n_start), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clk_uart  = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'hC35A3CA5;

    // Reset state, and no ready while rst_n is low
    @(negedge clk);
    @(negedge clk); req_valid = 4'b1111; #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd3);

    // Single request from requester 2, tick during START ignored
    @(negedge clk); rst_n = 1'b1; req_valid = 4'b0100; #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    chk("single_busy_idle", 32'(busy), 32'd0);
    @(negedge clk); clk_uart = 1'b1; req_valid = 4'b0001; #1;
    chk("single_tx_start", 32'(tx_start), 32'd1);
    chk("single_tx_data", 32'(tx_data), 32'h5A);
    chk("single_grant_id", 32'(grant_id), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    chk("start_ready_zero", 32'(req_ready), 32'd0);
    n_start = 0;
    frame_ticks(10);
    chk("after10_busy", 32'(busy), 32'd1);
    chk("after10_ready", 32'(req_ready), 32'd0);
    frame_ticks(1);
    chk("after11_busy", 32'(busy), 32'd0);
    chk("after11_ready", 32'(req_ready), 32'b0001);
    chk("single_one_start", 32'(n_start), 32'd0);

    // Grant requester 0, then reset mid-frame
    @(negedge clk); req_valid = 4'b0000; #1;
    chk("second_tx_start", 32'(tx_start), 32'd1);
    chk("second_tx_data", 32'(tx_data), 32'hA5);
    chk("second_grant_id", 32'(grant_id), 32'd0);
    n_start = 0;
    frame_ticks(5);
    @(negedge clk); rst_n = 1'b0; req_valid = 4'b0110; clk_uart = 1'b0; #1;
    chk("midrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd3);
    chk("midrst_ready_low", 32'(req_ready), 32'b0010);
    chk("midrst_no_start", 32'(n_start), 32'd0);
    @(negedge clk); req_valid = 4'b0000; #1;
    chk("postrst_tx_start", 32'(tx_start), 32'd1);
    chk("postrst_grant_id", 32'(grant_id), 32'd1);
    chk("postrst_tx_data", 32'(tx_data), 32'h3C);

    // All four requesting continuously
    do_reset();
    req_valid = 4'b1111; #1;
    for (int g = 0; g < 5; g++) grant_round(exp_all[g]);

    // Requesters 1 and 3 held
    do_reset();
    req_valid = 4'b1010; #1;
    for (int g = 0; g < 3; g++) grant_round(exp_odd[g]);

    // GAP_TICKS=0 instance regrants on the cycle after the 10th tick
    do_reset();
    req_valid = 4'b1000; #1;
    chk("g0_ready", 32'(req_ready0), 32'b1000);
    chk("g1_ready", 32'(req_ready), 32'b1000);
    @(negedge clk); #1;
    chk("g0_tx_start", 32'(tx_start0), 32'd1);
    chk("g0_tx_data", 32'(tx_data0), 32'hC3);
    frame_ticks(10);
    chk("g0_regrant", 32'(req_ready0), 32'b1000);
    chk("g0_idle", 32'(busy0), 32'd0);
    chk("g1_still_busy", 32'(busy), 32'd1);
    chk("g1_no_ready", 32'(req_ready), 32'd0);
    frame_ticks(1);
    chk("g1_regrant", 32'(req_ready), 32'b1000);
    chk("g0_busy_again", 32'(busy0), 32'd1);
    chk("g0_grant_id", 32'(grant_id0), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
